mem_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction cache (loads only) and the data cache (loads and stores).
- Grant is combinational. Request priority is round-robin with an anti-starvation override.
- A 15-entry tag-owner table routes returned load data to the requester that issued it.
- Sits between the pipeline's two cache controllers and the `mem` model at the pipeline top level.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter_tag_owner_table.sv | 36 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the unified-memory arbiter: command encodings,
// requester identifiers and the tag-owner table entry format.
package mem_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } REQ_ID;

  typedef struct packed {
    logic  valid;
    REQ_ID who;
  } TAG_OWNER_ENTRY;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and memory.
// slave = arbiter side, master = the caches/memory environment.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
;

  BUS_COMMAND       icache_command;
  logic [XLEN-1:0]  icache_addr;
  logic [3:0]       icache_response;
  logic [3:0]       icache_tag;

  BUS_COMMAND       dcache_command;
  logic [XLEN-1:0]  dcache_addr;
  logic [63:0]      dcache_data;
  logic [3:0]       dcache_response;
  logic [3:0]       dcache_tag;

  logic [63:0]      mem2proc_data_o;
  BUS_COMMAND       proc2mem_command;
  logic [XLEN-1:0]  proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;

  logic [2:0]       i_outstanding;
  logic [2:0]       d_outstanding;

  modport slave (
    input  icache_command, icache_addr,
    input  dcache_command, dcache_addr, dcache_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output icache_response, icache_tag, dcache_response, dcache_tag,
    output mem2proc_data_o, proc2mem_command, proc2mem_addr, proc2mem_data,
    output i_outstanding, d_outstanding
  );

  modport master (
    output icache_command, icache_addr,
    output dcache_command, dcache_addr, dcache_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  icache_response, icache_tag, dcache_response, dcache_tag,
    input  mem2proc_data_o, proc2mem_command, proc2mem_addr, proc2mem_data,
    input  i_outstanding, d_outstanding
  );

endinterface

// File: rtl/mem_arbiter_tag_owner_table.sv
// Records which requester issued each in-flight memory tag. A write from an
// acceptance beats a clear from a return when both hit the same tag.
module mem_arbiter_tag_owner_table
  import mem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [3:0]     wr_tag,
  input  REQ_ID          wr_who,
  input  logic           clr_en,
  input  logic [3:0]     rd_tag,
  output TAG_OWNER_ENTRY rd_entry,
  input  logic [3:0]     chk_tag,
  output TAG_OWNER_ENTRY chk_entry
);

  TAG_OWNER_ENTRY owner [NUM_MEM_TAGS];

  // Per-entry update: reset clears, acceptance writes, return clears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (reset) begin
        owner[i] <= '0;
      end else if (wr_en && (wr_tag == 4'(i))) begin
        owner[i] <= '{valid: 1'b1, who: wr_who};
      end else if (clr_en && (rd_tag == 4'(i))) begin
        owner[i] <= '0;
      end
    end
  end

  assign rd_entry  = owner[rd_tag];
  assign chk_entry = owner[chk_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified memory port between icache (loads) and dcache (loads and
// stores). Combinational round-robin grant with a starvation override, per-
// requester in-flight load limits, and tag-based routing of returned data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = 3;

  logic [CW-1:0]  i_cnt, d_cnt;
  logic [SW-1:0]  i_starve, d_starve;
  REQ_ID          rr_last;

  logic           i_elig, d_elig, pick_d, gnt_i, gnt_d, gnt_any;
  logic           i_full, d_full;
  BUS_COMMAND     gnt_cmd;
  logic           accepted, acc_load, acc_i, acc_d;
  logic           ret_hit, ret_i, ret_d;
  TAG_OWNER_ENTRY ret_entry, chk_entry;

  // Eligibility: loads respect the in-flight limit, stores never do; icache stores are ignored.
  assign i_elig = !reset && (bus.icache_command == BUS_LOAD) && (i_cnt < CW'(MAX_OUTSTANDING));
  assign d_elig = !reset && (((bus.dcache_command == BUS_LOAD) && (d_cnt < CW'(MAX_OUTSTANDING)))
                             || (bus.dcache_command == BUS_STORE));
  assign i_full = (i_starve == SW'(STARVE_LIMIT));
  assign d_full = (d_starve == SW'(STARVE_LIMIT));

  // Grant choice: lone requester, then starved requester, then not-last-served.
  always_comb begin
    pick_d = 1'b0;
    if (d_elig && !i_elig) begin
      pick_d = 1'b1;
    end else if (i_elig && d_elig) begin
      if (i_full && !d_full)      pick_d = 1'b0;
      else if (d_full && !i_full) pick_d = 1'b1;
      else                        pick_d = (rr_last == REQ_ICACHE);
    end
  end

  assign gnt_any = i_elig || d_elig;
  assign gnt_d   = gnt_any && pick_d;
  assign gnt_i   = gnt_any && !pick_d;

  // Memory-side drive and acceptance routing for the granted requester.
  always_comb begin
    gnt_cmd            = BUS_NONE;
    bus.proc2mem_addr  = '0;
    bus.proc2mem_data  = '0;
    if (gnt_d) begin
      gnt_cmd           = bus.dcache_command;
      bus.proc2mem_addr = bus.dcache_addr;
      bus.proc2mem_data = bus.dcache_data;
    end else if (gnt_i) begin
      gnt_cmd           = bus.icache_command;
      bus.proc2mem_addr = bus.icache_addr;
    end
  end

  assign bus.proc2mem_command = gnt_cmd;
  assign accepted             = gnt_any && (bus.mem2proc_response != 4'd0);
  assign acc_load             = accepted && (gnt_cmd == BUS_LOAD);
  assign acc_i                = acc_load && gnt_i;
  assign acc_d                = acc_load && gnt_d;
  assign bus.icache_response  = gnt_i ? bus.mem2proc_response : 4'd0;
  assign bus.dcache_response  = gnt_d ? bus.mem2proc_response : 4'd0;

  // Return routing: only tags with a valid owner reach a cache.
  assign ret_hit = !reset && (bus.mem2proc_tag != 4'd0) && ret_entry.valid;
  assign ret_i   = ret_hit && (ret_entry.who == REQ_ICACHE);
  assign ret_d   = ret_hit && (ret_entry.who == REQ_DCACHE);

  assign bus.icache_tag      = ret_i ? bus.mem2proc_tag : 4'd0;
  assign bus.dcache_tag      = ret_d ? bus.mem2proc_tag : 4'd0;
  assign bus.mem2proc_data_o = reset ? 64'd0 : bus.mem2proc_data;
  assign bus.i_outstanding   = reset ? 3'd0 : i_cnt;
  assign bus.d_outstanding   = reset ? 3'd0 : d_cnt;

  mem_arbiter_tag_owner_table u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (acc_load),
    .wr_tag    (bus.mem2proc_response),
    .wr_who    (gnt_d ? REQ_DCACHE : REQ_ICACHE),
    .clr_en    (ret_hit),
    .rd_tag    (bus.mem2proc_tag),
    .rd_entry  (ret_entry),
    .chk_tag   (bus.mem2proc_response),
    .chk_entry (chk_entry)
  );

  // Counters, round-robin pointer and starvation tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt    <= '0;
      d_cnt    <= '0;
      i_starve <= '0;
      d_starve <= '0;
      rr_last  <= REQ_ICACHE;
    end else begin
      i_cnt <= i_cnt + CW'(acc_i) - CW'(ret_i);
      d_cnt <= d_cnt + CW'(acc_d) - CW'(ret_d);
      if (accepted) rr_last <= gnt_d ? REQ_DCACHE : REQ_ICACHE;

      if (!i_elig || (gnt_i && accepted)) i_starve <= '0;
      else if (!gnt_i && !i_full)         i_starve <= i_starve + SW'(1);

      if (!d_elig || (gnt_d && accepted)) d_starve <= '0;
      else if (!gnt_d && !d_full)         d_starve <= d_starve + SW'(1);
    end
  end

  a_no_realloc: assert property (@(posedge clk) disable iff (reset)
    acc_load |-> (!chk_entry.valid || (ret_hit && (bus.mem2proc_tag == bus.mem2proc_response))));
  a_cnt_max: assert property (@(posedge clk) disable iff (reset)
    (i_cnt <= CW'(MAX_OUTSTANDING)) && (d_cnt <= CW'(MAX_OUTSTANDING)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    ((ret_i && !acc_i) |-> (i_cnt != '0)) and ((ret_d && !acc_d) |-> (d_cnt != '0)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table followed by
// hand-written starvation and reset-with-outstanding sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(8), .MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    BUS_COMMAND      icmd;
    logic [XLEN-1:0] iaddr;
    BUS_COMMAND      dcmd;
    logic [XLEN-1:0] daddr;
    logic [63:0]     ddata;
    logic [3:0]      mresp;
    logic [3:0]      mtag;
    logic [63:0]     mdata;
    logic [3:0]      e_iresp;
    logic [3:0]      e_dresp;
    logic [3:0]      e_itag;
    logic [3:0]      e_dtag;
    BUS_COMMAND      e_cmd;
    logic [XLEN-1:0] e_addr;
    logic [63:0]     e_data;
    logic [2:0]      e_iout;
    logic [2:0]      e_dout;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic drive(input logic r, input BUS_COMMAND ic, input logic [XLEN-1:0] ia,
                       input BUS_COMMAND dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                       input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
    @(posedge clk);
    #1;
    reset                 = r;
    bus.icache_command    = ic;
    bus.icache_addr       = ia;
    bus.dcache_command    = dc;
    bus.dcache_addr       = da;
    bus.dcache_data       = dd;
    bus.mem2proc_response = mr;
    bus.mem2proc_tag      = mt;
    bus.mem2proc_data     = md;
    @(negedge clk);
  endtask

  initial begin
    reset                 = 1'b1;
    bus.icache_command    = BUS_NONE;
    bus.icache_addr       = '0;
    bus.dcache_command    = BUS_NONE;
    bus.dcache_addr       = '0;
    bus.dcache_data       = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_tag      = '0;
    bus.mem2proc_data     = '0;

    //           rst   icmd       iaddr     dcmd       daddr     ddata        mresp mtag  mdata         iresp dresp itag  dtag  cmd        addr      data         iout  dout
    vecs[0]  = '{1'b1, BUS_LOAD,  32'h100, BUS_LOAD,  32'h300, 64'h55,    4'd3, 4'd0, 64'h0,      4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd0, 3'd0};
    vecs[1]  = '{1'b0, BUS_LOAD,  32'h100, BUS_NONE,  32'h0,   64'h0,     4'd3, 4'd0, 64'h0,      4'd3, 4'd0, 4'd0, 4'd0, BUS_LOAD,  32'h100, 64'h0,    3'd0, 3'd0};
    vecs[2]  = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd0, 64'h0,      4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd1, 3'd0};
    vecs[3]  = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd3, 64'hAAAA,   4'd0, 4'd0, 4'd3, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd1, 3'd0};
    vecs[4]  = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd0, 64'h0,      4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd0, 3'd0};
    vecs[5]  = '{1'b0, BUS_LOAD,  32'h200, BUS_LOAD,  32'h300, 64'h55,    4'd1, 4'd0, 64'h0,      4'd0, 4'd1, 4'd0, 4'd0, BUS_LOAD,  32'h300, 64'h55,   3'd0, 3'd0};
    vecs[6]  = '{1'b0, BUS_LOAD,  32'h200, BUS_LOAD,  32'h300, 64'h55,    4'd2, 4'd0, 64'h0,      4'd2, 4'd0, 4'd0, 4'd0, BUS_LOAD,  32'h200, 64'h0,    3'd0, 3'd1};
    vecs[7]  = '{1'b0, BUS_LOAD,  32'h200, BUS_LOAD,  32'h300, 64'h55,    4'd4, 4'd0, 64'h0,      4'd0, 4'd4, 4'd0, 4'd0, BUS_LOAD,  32'h300, 64'h55,   3'd1, 3'd1};
    vecs[8]  = '{1'b0, BUS_LOAD,  32'h200, BUS_LOAD,  32'h300, 64'h55,    4'd5, 4'd0, 64'h0,      4'd5, 4'd0, 4'd0, 4'd0, BUS_LOAD,  32'h200, 64'h0,    3'd1, 3'd2};
    vecs[9]  = '{1'b0, BUS_NONE,  32'h0,   BUS_LOAD,  32'h400, 64'h77,    4'd5, 4'd5, 64'h1234,   4'd0, 4'd5, 4'd5, 4'd0, BUS_LOAD,  32'h400, 64'h77,   3'd2, 3'd2};
    vecs[10] = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd5, 64'h0,      4'd0, 4'd0, 4'd0, 4'd5, BUS_NONE,  32'h0,   64'h0,    3'd1, 3'd3};
    vecs[11] = '{1'b0, BUS_NONE,  32'h0,   BUS_LOAD,  32'h500, 64'h0,     4'd6, 4'd1, 64'h0,      4'd0, 4'd6, 4'd0, 4'd1, BUS_LOAD,  32'h500, 64'h0,    3'd1, 3'd2};
    vecs[12] = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd7, 64'h0,      4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd1, 3'd2};
    vecs[13] = '{1'b0, BUS_NONE,  32'h0,   BUS_LOAD,  32'h600, 64'h0,     4'd7, 4'd0, 64'h0,      4'd0, 4'd7, 4'd0, 4'd0, BUS_LOAD,  32'h600, 64'h0,    3'd1, 3'd2};
    vecs[14] = '{1'b0, BUS_NONE,  32'h0,   BUS_LOAD,  32'h610, 64'h0,     4'd8, 4'd0, 64'h0,      4'd0, 4'd8, 4'd0, 4'd0, BUS_LOAD,  32'h610, 64'h0,    3'd1, 3'd3};
    vecs[15] = '{1'b0, BUS_LOAD,  32'h700, BUS_LOAD,  32'h620, 64'h0,     4'd9, 4'd0, 64'h0,      4'd9, 4'd0, 4'd0, 4'd0, BUS_LOAD,  32'h700, 64'h0,    3'd1, 3'd4};
    vecs[16] = '{1'b0, BUS_NONE,  32'h0,   BUS_STORE, 32'h800, 64'hDEAD,  4'd10, 4'd0, 64'h0,     4'd0, 4'd10, 4'd0, 4'd0, BUS_STORE, 32'h800, 64'hDEAD, 3'd2, 3'd4};
    vecs[17] = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd10, 64'h0,     4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd2, 3'd4};
    vecs[18] = '{1'b0, BUS_NONE,  32'h0,   BUS_LOAD,  32'h630, 64'h0,     4'd11, 4'd0, 64'h0,     4'd0, 4'd0, 4'd0, 4'd0, BUS_NONE,  32'h0,   64'h0,    3'd2, 3'd4};
    vecs[19] = '{1'b0, BUS_NONE,  32'h0,   BUS_NONE,  32'h0,   64'h0,     4'd0, 4'd4, 64'h0,      4'd0, 4'd0, 4'd0, 4'd4, BUS_NONE,  32'h0,   64'h0,    3'd2, 3'd4};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].icmd, vecs[i].iaddr, vecs[i].dcmd, vecs[i].daddr,
            vecs[i].ddata, vecs[i].mresp, vecs[i].mtag, vecs[i].mdata);
      chk($sformatf("v%0d.iresp", i), 64'(bus.icache_response),  64'(vecs[i].e_iresp));
      chk($sformatf("v%0d.dresp", i), 64'(bus.dcache_response),  64'(vecs[i].e_dresp));
      chk($sformatf("v%0d.itag",  i), 64'(bus.icache_tag),       64'(vecs[i].e_itag));
      chk($sformatf("v%0d.dtag",  i), 64'(bus.dcache_tag),       64'(vecs[i].e_dtag));
      chk($sformatf("v%0d.cmd",   i), 64'(bus.proc2mem_command), 64'(vecs[i].e_cmd));
      chk($sformatf("v%0d.addr",  i), 64'(bus.proc2mem_addr),    64'(vecs[i].e_addr));
      chk($sformatf("v%0d.data",  i), bus.proc2mem_data,         vecs[i].e_data);
      chk($sformatf("v%0d.iout",  i), 64'(bus.i_outstanding),    64'(vecs[i].e_iout));
      chk($sformatf("v%0d.dout",  i), 64'(bus.d_outstanding),    64'(vecs[i].e_dout));
      chk($sformatf("v%0d.mdo",   i), bus.mem2proc_data_o,       vecs[i].rst ? 64'h0 : vecs[i].mdata);
    end

    // Starvation: memory rejects while both request; icache is forced at its 9th losing cycle.
    drive(1'b1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, BUS_LOAD, 32'h900, BUS_LOAD, 32'hA00, 64'h0, 4'd0, 4'd0, 64'h0);
      chk($sformatf("starve%0d.addr", k), 64'(bus.proc2mem_addr), (k < 8) ? 64'hA00 : 64'h900);
      chk($sformatf("starve%0d.iresp", k), 64'(bus.icache_response), 64'h0);
    end
    drive(1'b0, BUS_LOAD, 32'h900, BUS_LOAD, 32'hA00, 64'h0, 4'd7, 4'd0, 64'h0);
    chk("starve_acc.iresp", 64'(bus.icache_response), 64'h7);
    chk("starve_acc.dresp", 64'(bus.dcache_response), 64'h0);
    drive(1'b0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    chk("starve_after.iout", 64'(bus.i_outstanding), 64'h1);

    // Reset with loads in flight: later returns of the old tags are dropped.
    for (int t = 1; t <= 3; t++) begin
      drive(1'b0, BUS_NONE, 32'h0, BUS_LOAD, 32'(32'hB00 + t), 64'h0, 4'(t), 4'd0, 64'h0);
      chk($sformatf("pre_rst%0d.dresp", t), 64'(bus.dcache_response), 64'(t));
    end
    drive(1'b0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    chk("pre_rst.dout", 64'(bus.d_outstanding), 64'h3);
    chk("pre_rst.iout", 64'(bus.i_outstanding), 64'h1);
    drive(1'b1, BUS_LOAD, 32'h900, BUS_LOAD, 32'hA00, 64'h0, 4'd2, 4'd1, 64'h99);
    chk("in_rst.cmd",   64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("in_rst.dresp", 64'(bus.dcache_response),  64'h0);
    chk("in_rst.dtag",  64'(bus.dcache_tag),       64'h0);
    chk("in_rst.mdo",   bus.mem2proc_data_o,       64'h0);
    for (int t = 1; t <= 3; t++) begin
      drive(1'b0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'(t), 64'h0);
      chk($sformatf("post_rst%0d.itag", t), 64'(bus.icache_tag),    64'h0);
      chk($sformatf("post_rst%0d.dtag", t), 64'(bus.dcache_tag),    64'h0);
      chk($sformatf("post_rst%0d.iout", t), 64'(bus.i_outstanding), 64'h0);
      chk($sformatf("post_rst%0d.dout", t), 64'(bus.d_outstanding), 64'h0);
    end
    drive(1'b0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'h0);
    chk("post_rst7.itag", 64'(bus.icache_tag), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
